reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back stage of the simple 16-bit CPU, the write-side counterpart of the 4-entry register group. It accepts one retired instruction from execute, optionally fetches a load operand from data memory, then drives the one-hot register write enable and write data into the register group and signals completion to fetch/control. It is a multi-cycle FSM with a memory request/acknowledge handshake and a load timeout.

## Interface
- DATA_W, 16, data/address width
- NREG, 4, number of registers; reg_en width, one-hot
- TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- en_in  in  1  one-cycle pulse: instruction fields below are valid
- wb_en  in  1  instruction writes a register
- is_load  in  1  write data comes from memory; alu_res is the address
- rd  in  2  destination register index
- alu_res  in  DATA_W  ALU result or load address
- mem_rd  out  1  memory read request, level
- mem_addr  out  DATA_W  read address, stable while mem_rd=1
- mem_data  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  memory acknowledge, one cycle
- reg_en  out  NREG  one-hot register write enable to register group
- d_out  out  DATA_W  register write data
- en_out  out  1  one-cycle pulse: write-back complete, register state updated
- busy  out  1  instruction in flight (state ≠ IDLE)
- err  out  1  sticky: last load timed out

## Operation
- States: IDLE, MEM_WAIT, WRITE, DONE.
- IDLE: on en_in=1 capture wb_en, is_load, rd, alu_res; clear err. is_load=1 and wb_en=1 → MEM_WAIT; otherwise → WRITE.
- is_load=1 with wb_en=0 is treated as no-write, no memory access.
- MEM_WAIT: mem_rd=1, mem_addr=captured alu_res; timeout counter increments each cycle. mem_ack=1 → capture mem_data, → WRITE. Counter reaches TIMEOUT with no ack → err=1, → DONE (no register write).
- mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
- WRITE: d_out = captured data; reg_en = one-hot(rd) if wb_en else 0; → DONE.
- DONE: en_out=1 for one cycle; → IDLE.
- en_in while busy=1 is ignored (upstream contract: never issued); mem_ack outside MEM_WAIT is ignored.
- All outputs registered. Reset (any state, mid-load included): state IDLE, reg_en=0, d_out=0, mem_rd=0, mem_addr=0, en_out=0, busy=0, err=0, counter 0; an outstanding memory request is abandoned.

## Timing
- Cycle 0 = en_in sampled high.
- Non-load: reg_en/d_out valid cycle 1 (exactly one cycle), en_out cycle 2; next en_in accepted cycle 3.
- Load, ack in cycle k (k≥1): mem_rd high cycles 1..k, drops cycle k+1; reg_en cycle k+1; en_out cycle k+2.
- Timeout: mem_rd high cycles 1..TIMEOUT, err rises and en_out pulses cycle TIMEOUT+1, err held until next accepted en_in or reset.
- reg_en never has more than one bit set; d_out holds last written value between writes.

## Structure
- Shared CPU package: state encoding (2-bit enum), DATA_W, NREG, TIMEOUT default, register-index width.
- Single module; one-hot decode and timeout counter inline, no sub-module.

## Test plan
- Reset mid-MEM_WAIT (rst low 1 cycle) → all outputs 0 immediately, state IDLE, no later reg_en or en_out.
- ALU write: en_in, wb_en=1, is_load=0, rd=2, alu_res=16'h1234 → cycle 1 reg_en=4'b0100, d_out=16'h1234; cycle 2 en_out=1.
- No-write: wb_en=0, rd=3 → reg_en stays 4'b0000, en_out in cycle 2.
- Load: is_load=1, wb_en=1, rd=1, alu_res=16'h0040, mem_ack+mem_data=16'hBEEF in cycle 3 → mem_rd=1/mem_addr=16'h0040 cycles 1–3, reg_en=4'b0010 d_out=16'hBEEF cycle 4, en_out cycle 5.
- Timeout, TIMEOUT=15, no ack → mem_rd cycles 1–15, err=1 and en_out cycle 16, no reg_en; next ALU instruction clears err.
- Ack on the timeout cycle (cycle 15) → err stays 0, write in cycle 16, en_out cycle 17.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared CPU definitions for the write-back stage: datapath widths, register-file
// geometry, load timeout default and the write-back FSM state encoding.
package reg_writeback_pkg;

    localparam int unsigned CPU_DATA_W  = 16;
    localparam int unsigned CPU_NREG    = 4;
    localparam int unsigned CPU_RIDX_W  = 2;
    localparam int unsigned CPU_TIMEOUT = 15;
    localparam int unsigned CPU_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } wb_state_e;

endpackage

// File: rtl/reg_writeback.sv
// Write-back stage: takes one retired instruction, optionally fetches a load
// operand with a bounded memory handshake, then writes the register group.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned NREG    = CPU_NREG,
    parameter int unsigned TIMEOUT = CPU_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_in,
    input  logic                  wb_en,
    input  logic                  is_load,
    input  logic [CPU_RIDX_W-1:0] rd,
    input  logic [DATA_W-1:0]     alu_res,
    output logic                  mem_rd,
    output logic [DATA_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_ack,
    output logic [NREG-1:0]       reg_en,
    output logic [DATA_W-1:0]     d_out,
    output logic                  en_out,
    output logic                  busy,
    output logic                  err
);

    localparam logic [CPU_CNT_W-1:0] TIMEOUT_C = CPU_CNT_W'(TIMEOUT);

    wb_state_e               state_q, state_d;
    logic                    wb_q, wb_d;
    logic [CPU_RIDX_W-1:0]   rd_q, rd_d;
    logic [CPU_CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [NREG-1:0]         reg_en_q, reg_en_d;
    logic [DATA_W-1:0]       d_out_q, d_out_d;
    logic                    en_out_q, en_out_d;
    logic                    busy_q, busy_d;
    logic [DATA_W-1:0]       wdata;
    logic                    write_d;

    assign cnt_inc = cnt_q + CPU_CNT_W'(1);

    // Next-state logic; every registered output is decoded from the next state
    // so outputs line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (en_in) begin
                    wb_d  = wb_en;
                    rd_d  = rd;
                    err_d = 1'b0;
                    cnt_d = '0;
                    wdata = alu_res;
                    if (is_load && wb_en) begin
                        mem_addr_d = alu_res;
                        state_d    = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_MEM_WAIT: begin
                cnt_d = cnt_inc;
                // ack beats the timeout when both land on the same cycle
                if (mem_ack) begin
                    wdata   = mem_data;
                    state_d = ST_WRITE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        write_d  = (state_d == ST_WRITE) && wb_d;
        mem_rd_d = (state_d == ST_MEM_WAIT);
        en_out_d = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);

        reg_en_d = '0;
        d_out_d  = d_out_q;
        if (write_d) begin
            d_out_d = wdata;
            for (int unsigned i = 0; i < NREG; i++) begin
                reg_en_d[i] = (rd_d == CPU_RIDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wb_q       <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            reg_en_q   <= '0;
            d_out_q    <= '0;
            en_out_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            reg_en_q   <= reg_en_d;
            d_out_q    <= d_out_d;
            en_out_q   <= en_out_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign reg_en   = reg_en_q;
    assign d_out    = d_out_q;
    assign en_out   = en_out_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a scoreboard of expected register
// writes and completion pulses, each tagged with the cycle it must appear in.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_in = 1'b0, wb_en = 1'b0, is_load = 1'b0;
    logic [1:0]  rd = '0;
    logic [15:0] alu_res = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        mem_ack = 1'b0;
    logic [3:0]  reg_en;
    logic [15:0] d_out;
    logic        en_out, busy, err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct { logic [3:0] en; logic [15:0] d; int cyc; } wr_t;
    typedef struct { logic err; int cyc; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    reg_writeback #(.DATA_W(16), .NREG(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .wb_en(wb_en), .is_load(is_load),
        .rd(rd), .alu_res(alu_res), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .reg_en(reg_en), .d_out(d_out),
        .en_out(en_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive an instruction at a falling edge; returns the edge number that samples it.
    task automatic drive_start(input logic w, input logic l, input logic [1:0] r,
                               input logic [15:0] a, output int c0);
        @(negedge clk);
        en_in = 1'b1; wb_en = w; is_load = l; rd = r; alu_res = a;
        c0 = cyc + 1;
    endtask

    task automatic drive_end();
        @(negedge clk);
        en_in = 1'b0; wb_en = 1'b0; is_load = 1'b0; rd = '0; alu_res = '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (reg_en != 4'b0000) begin
                if (wq.size() == 0) begin
                    check("unexpected_reg_en", {28'd0, reg_en}, 32'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_reg_en", {28'd0, reg_en}, {28'd0, e.en});
                    check("wr_d_out", {16'd0, d_out}, {16'd0, e.d});
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (en_out) begin
                if (dq.size() == 0) begin
                    check("unexpected_en_out", {31'd0, en_out}, 32'd0);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    check("done_err", {31'd0, err}, {31'd0, e.err});
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_en", {28'd0, reg_en}, 32'd0);
        check("rst_d_out", {16'd0, d_out}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_en_out", {31'd0, en_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU write rd=2
        drive_start(1'b1, 1'b0, 2'd2, 16'h1234, c0);
        wq.push_back('{4'b0100, 16'h1234, c0});
        dq.push_back('{1'b0, c0 + 1});
        drive_end();
        check("alu_busy", {31'd0, busy}, 32'd1);
        check("alu_mem_rd", {31'd0, mem_rd}, 32'd0);
        repeat (3) @(negedge clk);
        check("alu_idle", {31'd0, busy}, 32'd0);

        // No-write rd=3: d_out keeps the previous write
        drive_start(1'b0, 1'b0, 2'd3, 16'h9999, c0);
        dq.push_back('{1'b0, c0 + 1});
        drive_end();
        repeat (3) @(negedge clk);
        check("nowr_d_hold", {16'd0, d_out}, 32'h1234);

        // Load rd=1 with ack in cycle 3
        drive_start(1'b1, 1'b1, 2'd1, 16'h0040, c0);
        wq.push_back('{4'b0010, 16'hBEEF, c0 + 3});
        dq.push_back('{1'b0, c0 + 4});
        drive_end();
        for (int k = 1; k <= 3; k++) begin
            check("ld_mem_rd", {31'd0, mem_rd}, 32'd1);
            check("ld_mem_addr", {16'd0, mem_addr}, 32'h0040);
            if (k == 3) begin mem_ack = 1'b1; mem_data = 16'hBEEF; end
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_data = '0;
        check("ld_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        repeat (3) @(negedge clk);

        // Timeout: no ack for 15 cycles
        drive_start(1'b1, 1'b1, 2'd0, 16'h0080, c0);
        dq.push_back('{1'b1, c0 + 15});
        drive_end();
        for (int k = 1; k <= 15; k++) begin
            check("to_mem_rd", {31'd0, mem_rd}, 32'd1);
            @(negedge clk);
        end
        check("to_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", {31'd0, err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);

        // Next ALU instruction clears err
        drive_start(1'b1, 1'b0, 2'd3, 16'h5A5A, c0);
        wq.push_back('{4'b1000, 16'h5A5A, c0});
        dq.push_back('{1'b0, c0 + 1});
        drive_end();
        check("clr_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);

        // Ack on the timeout cycle wins
        drive_start(1'b1, 1'b1, 2'd2, 16'h0100, c0);
        wq.push_back('{4'b0100, 16'hCAFE, c0 + 15});
        dq.push_back('{1'b0, c0 + 16});
        drive_end();
        for (int k = 1; k <= 15; k++) begin
            check("race_mem_rd", {31'd0, mem_rd}, 32'd1);
            if (k == 15) begin mem_ack = 1'b1; mem_data = 16'hCAFE; end
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_data = '0;
        check("race_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("race_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_data = 16'h1111;
        @(negedge clk);
        mem_ack = 1'b0; mem_data = '0;
        repeat (2) @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_d_hold", {16'd0, d_out}, 32'hCAFE);

        // Load without write-enable: no memory access
        drive_start(1'b0, 1'b1, 2'd1, 16'h0222, c0);
        dq.push_back('{1'b0, c0 + 1});
        drive_end();
        check("ldnw_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("ldnw_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a load
        drive_start(1'b1, 1'b1, 2'd3, 16'h0200, c0);
        drive_end();
        @(negedge clk);
        check("mid_mem_rd", {31'd0, mem_rd}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("mid_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_d_out", {16'd0, d_out}, 32'd0);
        check("mid_rst_reg_en", {28'd0, reg_en}, 32'd0);
        check("mid_rst_en_out", {31'd0, en_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Recovers normally after reset
        drive_start(1'b1, 1'b0, 2'd0, 16'h0F0F, c0);
        wq.push_back('{4'b0001, 16'h0F0F, c0});
        dq.push_back('{1'b0, c0 + 1});
        drive_end();
        repeat (4) @(negedge clk);

        check("wq_drained", wq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
